// File: rtl/nibble_stack_pkg.sv
// Shared types and constants for the nibble stack.
// The stack is built with the NIBBLE_STACK_ERR_FLAGS_EN macro optionally defined.
package stack_pkg;
    localparam int WORD_W = 4;

    // Direction encodings for a move strobe
    localparam logic STK_PUSH = 1'b1;
    localparam logic STK_POP  = 1'b0;

    // Next-value source for a single stack entry
    typedef enum logic [2:0] {
        CELL_HOLD,
        CELL_LOAD,
        CELL_ABOVE,
        CELL_BELOW,
        CELL_SWAP,
        CELL_ZERO
    } cell_sel_t;
endpackage

// File: rtl/nibble_stack_if.sv
// Handshake/data bundle between the stack CPU control and the nibble stack.
interface nibble_stack_if
    import stack_pkg::*;
#(
    parameter int DEPTH = 8
) ();
    localparam int DW = $clog2(DEPTH + 1);

    logic              mode;
    logic              move;
    logic              swap;
    logic [WORD_W-1:0] in_word;
    logic [WORD_W-1:0] top_word;
    logic [WORD_W-1:0] second_word;
    logic [DW-1:0]     depth;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    // CPU side: issues strobes, reads the top entries and status
    modport master (
        output mode, move, swap, in_word,
        input  top_word, second_word, depth, full, empty, overflow, underflow
    );

    // Stack side
    modport slave (
        input  mode, move, swap, in_word,
        output top_word, second_word, depth, full, empty, overflow, underflow
    );
endinterface

// File: rtl/nibble_stack_cell.sv
// One stack entry: a word register with its next-value mux.
module nibble_stack_cell
    import stack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  cell_sel_t         sel,
    input  logic [WORD_W-1:0] in_word,
    input  logic [WORD_W-1:0] above,
    input  logic [WORD_W-1:0] below,
    input  logic [WORD_W-1:0] partner,
    output logic [WORD_W-1:0] q
);
    // Register the selected source; reset clears the entry
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (sel)
                CELL_LOAD:  q <= in_word;
                CELL_ABOVE: q <= above;
                CELL_BELOW: q <= below;
                CELL_SWAP:  q <= partner;
                CELL_ZERO:  q <= '0;
                default:    q <= q;
            endcase
        end
    end
endmodule

// File: rtl/nibble_stack.sv
// Parameterised LIFO of 4-bit words with occupancy and optional sticky error flags.
// Optional macro: NIBBLE_STACK_ERR_FLAGS_EN builds the overflow/underflow registers;
// without it both flags read 0.
module nibble_stack
    import stack_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic          clk,
    input logic          rst,
    nibble_stack_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WORD_W-1:0] entry;
    logic [DW-1:0]                depth_q;

    logic push, pop;
    assign push = bus.move && (bus.mode == STK_PUSH);
    assign pop  = bus.move && (bus.mode == STK_POP);

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        cell_sel_t         sel;
        logic [WORD_W-1:0] above, below, partner;

        if (i == 0) begin : g_top
            assign above = bus.in_word;
        end else begin : g_inner_a
            assign above = entry[i-1];
        end

        if (i == DEPTH - 1) begin : g_bot
            assign below = '0;
        end else begin : g_inner_b
            assign below = entry[i+1];
        end

        if (i == 0) begin : g_p0
            assign partner = entry[1];
        end else if (i == 1) begin : g_p1
            assign partner = entry[0];
        end else begin : g_pn
            assign partner = '0;
        end

        // Move beats swap; only the top two entries take part in a swap
        always_comb begin
            sel = CELL_HOLD;
            if (push) begin
                sel = (i == 0) ? CELL_LOAD : CELL_ABOVE;
            end else if (pop) begin
                sel = (i == DEPTH - 1) ? CELL_ZERO : CELL_BELOW;
            end else if (bus.swap && i < 2) begin
                sel = CELL_SWAP;
            end
        end

        nibble_stack_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .sel     (sel),
            .in_word (bus.in_word),
            .above   (above),
            .below   (below),
            .partner (partner),
            .q       (entry[i])
        );
    end

    // Occupancy counter, saturating at both ends
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else if (push && depth_q != DW'(DEPTH)) begin
            depth_q <= depth_q + 1'b1;
        end else if (pop && depth_q != '0) begin
            depth_q <= depth_q - 1'b1;
        end
    end

    assign bus.top_word    = entry[0];
    assign bus.second_word = entry[1];
    assign bus.depth       = depth_q;
    assign bus.full        = (depth_q == DW'(DEPTH));
    assign bus.empty       = (depth_q == '0);

`ifdef NIBBLE_STACK_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push && bus.full)  ovf_q <= 1'b1;
            if (pop  && bus.empty) unf_q <= 1'b1;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
endmodule
